// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder that time-shares one half adder, two passes per bit, LSB first.
// Optional subtraction (sub port, B inverted with carry-in 1) when SERIAL_ADDER_SUB_EN is defined.

module half_adder (
    input  logic a,
    input  logic b,
    output logic carry,
    output logic sum
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]    cnt;
    logic             carry_reg, s1_reg, c1_reg;
    logic             ha_a, ha_b, ha_carry, ha_sum;
    logic             new_carry;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's complement subtract: A + ~B + 1.
    assign b_load = sub ? ~op_b : op_b;
    assign c_load = sub;
`else
    assign b_load = op_b;
    assign c_load = 1'b0;
`endif

    half_adder u_ha (
        .a     (ha_a),
        .b     (ha_b),
        .carry (ha_carry),
        .sum   (ha_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ha_a      = 1'b0;
        ha_b      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = PH1;
            PH1: begin
                ha_a      = a_sh[0];
                ha_b      = b_sh[0];
                busy      = 1'b1;
                state_nxt = PH2;
            end
            PH2: begin
                ha_a      = s1_reg;
                ha_b      = carry_reg;
                busy      = 1'b1;
                state_nxt = (cnt == LAST) ? DONE : PH1;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // c1 and the second-pass carry are mutually exclusive, so OR is the full carry.
    assign new_carry = c1_reg | ha_carry;
    assign res_cat   = {ha_sum, result};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            carry_reg <= 1'b0;
            s1_reg    <= 1'b0;
            c1_reg    <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    a_sh      <= op_a;
                    b_sh      <= b_load;
                    carry_reg <= c_load;
                    cnt       <= '0;
                end
                PH1: begin
                    s1_reg <= ha_sum;
                    c1_reg <= ha_carry;
                end
                PH2: begin
                    result    <= res_cat[WIDTH:1];
                    carry_reg <= new_carry;
                    a_sh      <= a_sh >> 1;
                    b_sh      <= b_sh >> 1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) cout <= new_carry;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] result;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    // Reference: plain integer arithmetic on W+1 bits.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] nb;
        nb = ~b;
        if (s) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Drive one operation from IDLE (called #1 after an edge); report latency, busy count, outputs.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output int nbusy, output logic [W-1:0] res,
                          output logic co, output logic done_after);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        @(posedge clk); #1;
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        lat = 0; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        res = result; co = cout;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; #12;
        total++;
        if ({busy, done, result, cout} !== '0)
            $display("FAIL reset_state got busy=%b done=%b result=%h cout=%b exp all 0", busy, done, result, cout);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat, nb; logic [W-1:0] r; logic c, da;
        run_op(8'h00, 8'h00, 1'b0, lat, nb, r, c, da);
        total++;
        if (lat !== 2*W) $display("FAIL zero_latency got %0d exp %0d", lat, 2*W); else pass_cnt++;
        total++;
        if (nb !== 2*W) $display("FAIL zero_busy_cycles got %0d exp %0d", nb, 2*W); else pass_cnt++;
        total++;
        if ({c, r} !== 9'h000) $display("FAIL zero_sum got %b_%h exp 0_00", c, r); else pass_cnt++;
        total++;
        if (da !== 1'b0) $display("FAIL zero_done_width got %b exp 0", da); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [W-1:0] av [3] = '{8'hFF, 8'hA5, 8'h80};
        logic [W-1:0] bv [3] = '{8'h01, 8'h5A, 8'h80};
        logic [W:0]   ev [3] = '{9'h100, 9'h0FF, 9'h100};
        int lat, nb; logic [W-1:0] r; logic c, da;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], 1'b0, lat, nb, r, c, da);
            total++;
            if ({c, r} !== ev[i])
                $display("FAIL directed_%0d got %h exp %h", i, {c, r}, ev[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat, nb; logic [W-1:0] r, a, b; logic c, da, s; logic [W:0] e;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            e = model(a, b, s);
            run_op(a, b, s, lat, nb, r, c, da);
            total++;
            if ({c, r} !== e || lat !== 2*W)
                $display("FAIL random_%0d a=%h b=%h sub=%b got %h lat %0d exp %h lat %0d", i, a, b, s, {c, r}, lat, e, 2*W);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0; logic [W:0] got = '0;
        start = 1'b1; op_a = 8'h12; op_b = 8'h34; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; op_a = 8'hFF; op_b = 8'hFF;
        for (int j = 1; j <= 25; j++) begin
            if (done) begin ndone++; got = {cout, result}; end
            start = (j == 5 || j == 2*W);
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++;
        if (ndone !== 1) $display("FAIL ignore_done_count got %0d exp 1", ndone); else pass_cnt++;
        total++;
        if (got !== 9'h046) $display("FAIL ignore_sum got %h exp 046", got); else pass_cnt++;
        total++;
        if (busy !== 1'b0 || {cout, result} !== 9'h046)
            $display("FAIL ignore_after got busy=%b sum=%h exp 0 046", busy, {cout, result});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int seen = 0; int lat, nb; logic [W-1:0] r; logic c, da;
        start = 1'b1; op_a = 8'h0F; op_b = 8'h01; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, result, cout} !== '0)
            $display("FAIL async_reset got busy=%b done=%b result=%h cout=%b exp all 0", busy, done, result, cout);
        else pass_cnt++;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 20; j++) begin
            if (done || busy) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) $display("FAIL async_no_done got %0d active cycles exp 0", seen); else pass_cnt++;
        run_op(8'h03, 8'h04, 1'b0, lat, nb, r, c, da);
        total++;
        if ({c, r} !== 9'h007) $display("FAIL async_followup got %h exp 007", {c, r}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int pulses[$]; logic [W:0] sums[$]; int cyc = 0;
        start = 1'b1; op_a = 8'h01; op_b = 8'h01; sub = 1'b0;
        while (pulses.size() < 3 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (done) begin pulses.push_back(cyc); sums.push_back({cout, result}); end
        end
        start = 1'b0;
        total++;
        if (pulses.size() !== 3) $display("FAIL b2b_pulses got %0d exp 3", pulses.size());
        else pass_cnt++;
        for (int i = 0; i < pulses.size(); i++) begin
            total++;
            if (sums[i] !== 9'h002) $display("FAIL b2b_sum_%0d got %h exp 002", i, sums[i]); else pass_cnt++;
            if (i > 0) begin
                total++;
                if (pulses[i] - pulses[i-1] !== 2*W+2)
                    $display("FAIL b2b_spacing_%0d got %0d exp %0d", i, pulses[i] - pulses[i-1], 2*W+2);
                else pass_cnt++;
            end
        end
        repeat (2*W+4) @(posedge clk);
        #1;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [W-1:0] av [3] = '{8'h10, 8'h00, 8'h10};
        logic [W-1:0] bv [3] = '{8'h01, 8'h01, 8'h01};
        logic         sv [3] = '{1'b1, 1'b1, 1'b0};
        logic [W:0]   ev [3] = '{9'h10F, 9'h0FF, 9'h011};
        int lat, nb; logic [W-1:0] r; logic c, da;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], sv[i], lat, nb, r, c, da);
            total++;
            if ({c, r} !== ev[i] || lat !== 2*W)
                $display("FAIL sub_%0d got %h lat %0d exp %h lat %0d", i, {c, r}, lat, ev[i], 2*W);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_directed();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
